// File: rtl/shift_sequencer.sv
// shift_sequencer: valid/ready command controller that shifts a word into an external shift register and returns the loopback capture
//   clk, rst                                   : clock, synchronous active-high reset
//   i_cmd_valid, o_cmd_ready, i_cmd_dir, i_cmd_data : command handshake, shift direction, word to shift in
//   o_sr_d, o_sr_en, o_sr_dir, i_sr_out        : shift-register serial data, enable, direction, parallel readback
//   o_rsp_valid, i_rsp_ready, o_rsp_data, o_rsp_match : response handshake, captured word, loopback-match flag
module shift_sequencer #(
  parameter int MSB = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_cmd_valid,
  output logic           o_cmd_ready,
  input  logic           i_cmd_dir,
  input  logic [MSB-1:0] i_cmd_data,
  output logic           o_sr_d,
  output logic           o_sr_en,
  output logic           o_sr_dir,
  input  logic [MSB-1:0] i_sr_out,
  output logic           o_rsp_valid,
  input  logic           i_rsp_ready,
  output logic [MSB-1:0] o_rsp_data,
  output logic           o_rsp_match
);
  localparam int CW = $clog2(MSB + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, RESP} state_t;
  state_t         r_state, w_next;
  logic [MSB-1:0] r_shadow, r_word, r_rsp_data;
  logic [CW-1:0]  r_cnt;
  logic           r_dir, r_ready, r_match;
  logic           w_accept, w_last;
  always_comb begin
    w_accept = r_ready && i_cmd_valid;
    w_last   = r_cnt == CW'(MSB - 1);
    w_next   = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? SHIFT : IDLE;
      SHIFT:   w_next = w_last ? CAPTURE : SHIFT;
      CAPTURE: w_next = RESP;
      RESP:    w_next = i_rsp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  // cmd_ready is registered from the next state so it stays low through reset and rises only after release
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ready    <= 1'b0;
      r_dir      <= 1'b0;
      r_shadow   <= '0;
      r_word     <= '0;
      r_cnt      <= '0;
      r_rsp_data <= '0;
      r_match    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= w_next == IDLE;
      if (w_accept) begin
        r_shadow <= i_cmd_data;
        r_word   <= i_cmd_data;
        r_dir    <= i_cmd_dir;
        r_cnt    <= '0;
      end else if (r_state == SHIFT) begin
        r_shadow <= r_dir ? r_shadow >> 1 : r_shadow << 1;
        r_cnt    <= r_cnt + 1'b1;
      end
      if (r_state == CAPTURE) begin
        r_rsp_data <= i_sr_out;
        r_match    <= i_sr_out == r_word;
      end
    end
  end
  assign o_cmd_ready = r_ready;
  assign o_sr_en     = r_state == SHIFT;
  assign o_sr_d      = o_sr_en && (r_dir ? r_shadow[0] : r_shadow[MSB-1]);
  assign o_sr_dir    = r_dir;
  assign o_rsp_valid = r_state == RESP;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_match = r_match;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: table-driven scoreboard bench for shift_sequencer with an attached shift-register model
module tb_shift_sequencer;
  localparam int MSB = 4;
  logic           clk = 0, rst = 1;
  logic           i_cmd_valid = 0, i_cmd_dir = 0, i_rsp_ready = 1;
  logic [MSB-1:0] i_cmd_data = '0;
  logic           o_cmd_ready, o_sr_d, o_sr_en, o_sr_dir, o_rsp_valid, o_rsp_match;
  logic [MSB-1:0] o_rsp_data, i_sr_out, r_sr = '0;
  logic           force0 = 0;
  int             passed = 0, total = 0;
  typedef struct {logic [MSB-1:0] d; logic m;} exp_t;
  typedef struct {logic dir; logic [MSB-1:0] data; logic f; logic [MSB-1:0] ed; logic em;} vec_t;
  exp_t q[$];
  vec_t vecs[5];

  shift_sequencer #(.MSB(MSB)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_dir(i_cmd_dir), .i_cmd_data(i_cmd_data),
    .o_sr_d(o_sr_d), .o_sr_en(o_sr_en), .o_sr_dir(o_sr_dir), .i_sr_out(i_sr_out),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data), .o_rsp_match(o_rsp_match)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (o_sr_en) r_sr <= o_sr_dir ? {o_sr_d, r_sr[MSB-1:1]} : {r_sr[MSB-2:0], o_sr_d};
  assign i_sr_out = force0 ? '0 : r_sr;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h", nm, a, e);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && o_rsp_valid && i_rsp_ready) begin
      if (q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("rsp_data", o_rsp_data, e.d);
        chk("rsp_match", o_rsp_match, e.m);
      end
    end
  end

  task automatic send(input logic d, input logic [MSB-1:0] w, input logic f,
                      input logic [MSB-1:0] ed, input logic em);
    int n = 0;
    while (!o_cmd_ready && n < 40) begin tick(); n++; end
    chk("cmd_ready_wait", o_cmd_ready, 1);
    force0 = f;
    i_cmd_valid = 1; i_cmd_dir = d; i_cmd_data = w;
    q.push_back('{d: ed, m: em});
    tick();
    i_cmd_valid = 0;
    for (int i = 0; i < MSB; i++) begin
      chk("shift_en", o_sr_en, 1);
      chk("shift_dir", o_sr_dir, d);
      chk("shift_d", o_sr_d, d ? w[i] : w[MSB-1-i]);
      chk("shift_ready", o_cmd_ready, 0);
      tick();
    end
    chk("capture_en", o_sr_en, 0);
    chk("capture_d", o_sr_d, 0);
    chk("capture_valid", o_rsp_valid, 0);
    tick();
    chk("resp_valid", o_rsp_valid, 1);
    chk("resp_en", o_sr_en, 0);
    force0 = 0;
  endtask

  initial begin
    vecs[0] = '{dir: 0, data: 4'b1011, f: 0, ed: 4'b1011, em: 1};
    vecs[1] = '{dir: 1, data: 4'b0110, f: 0, ed: 4'b0110, em: 1};
    vecs[2] = '{dir: 0, data: 4'b1111, f: 1, ed: 4'b0000, em: 0};
    vecs[3] = '{dir: 1, data: 4'b1000, f: 0, ed: 4'b1000, em: 1};
    vecs[4] = '{dir: 0, data: 4'b0001, f: 0, ed: 4'b0001, em: 1};
    rst = 1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_ready", o_cmd_ready, 0);
      chk("rst_outs", {o_sr_d, o_sr_en, o_sr_dir, o_rsp_valid, o_rsp_match}, 0);
      chk("rst_data", o_rsp_data, 0);
    end
    rst = 0;
    tick();
    chk("ready_after_rst", o_cmd_ready, 1);
    for (int v = 0; v < 5; v++) begin
      send(vecs[v].dir, vecs[v].data, vecs[v].f, vecs[v].ed, vecs[v].em);
      tick();
      chk("idle_after_resp", o_cmd_ready, 1);
      chk("sr_dir_held", o_sr_dir, vecs[v].dir);
    end
    i_rsp_ready = 0;
    send(1, 4'b0011, 0, 4'b0011, 1);
    i_cmd_valid = 1; i_cmd_dir = 0; i_cmd_data = 4'b1100;
    q.push_back('{d: 4'b1100, m: 1});
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", o_rsp_valid, 1);
      chk("bp_data", o_rsp_data, 4'b0011);
      chk("bp_ready", o_cmd_ready, 0);
      chk("bp_en", o_sr_en, 0);
      tick();
    end
    i_rsp_ready = 1;
    tick();
    chk("bp_idle_ready", o_cmd_ready, 1);
    chk("bp_idle_valid", o_rsp_valid, 0);
    tick();
    i_cmd_valid = 0;
    chk("bp_accept_en", o_sr_en, 1);
    chk("bp_accept_d", o_sr_d, 1);
    chk("bp_accept_dir", o_sr_dir, 0);
    repeat (MSB + 1) tick();
    chk("bp_second_valid", o_rsp_valid, 1);
    tick();
    i_cmd_valid = 1; i_cmd_dir = 1; i_cmd_data = 4'b0110;
    tick();
    i_cmd_valid = 0;
    chk("abort_shift1", o_sr_en, 1);
    tick();
    chk("abort_shift2", o_sr_en, 1);
    rst = 1;
    tick();
    chk("abort_en", o_sr_en, 0);
    chk("abort_valid", o_rsp_valid, 0);
    chk("abort_ready", o_cmd_ready, 0);
    chk("abort_dir", o_sr_dir, 0);
    rst = 0;
    tick();
    chk("abort_ready_back", o_cmd_ready, 1);
    for (int c = 0; c < MSB + 3; c++) begin
      chk("abort_no_rsp", {o_rsp_valid, o_sr_en}, 0);
      tick();
    end
    send(0, 4'b1001, 0, 4'b1001, 1);
    for (int n = 0; n < 20 && q.size() != 0; n++) tick();
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Command-driven controller that sequences an external bidirectional shift register of width MSB. It accepts a parallel word and a direction over a valid/ready handshake. It then drives the register's serial input, enable and direction lines so that the word is shifted in bit by bit. Finally it captures the register's parallel output and returns it with a loopback-match flag over a second valid/ready handshake. It sits between a host/command source and the shift-register datapath, and is the sole driver of that register's control pins.

## Interface

- MSB, 4, width of the controlled shift register and of command/response data (MSB >= 2)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command (high only in IDLE)
- cmd_dir  in  1  shift direction for this command
- cmd_data  in  MSB  word to shift into the register
- sr_d  out  1  serial data to shift register input
- sr_en  out  1  shift enable to shift register
- sr_dir  out  1  direction to shift register; 0 = shift left (sr_d enters bit 0), 1 = shift right (sr_d enters bit MSB-1)
- sr_out  in  MSB  parallel output of the shift register
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumer ready
- rsp_data  out  MSB  captured sr_out
- rsp_match  out  1  1 when captured sr_out equals the latched command word

## Operation

- States: IDLE, SHIFT, CAPTURE, RESP.
- IDLE: cmd_ready=1, sr_en=0. When cmd_valid&&cmd_ready, latch cmd_data into a shadow register and cmd_dir into dir_q, clear the bit counter, and go to SHIFT.
- SHIFT: sr_en=1 and sr_dir=dir_q for exactly MSB cycles.
  - dir_q=0: send MSB-first (shadow[MSB-1] first, shadow shifts left each cycle).
  - dir_q=1: send LSB-first (shadow[0] first, shadow shifts right each cycle).
  - Either order leaves sr_out equal to the command word after the MSB shifts.
  - The counter is $clog2(MSB+1) bits. Leave SHIFT when the counter reaches MSB-1 at the clock edge.
- CAPTURE: one cycle with sr_en=0. Register rsp_data<=sr_out and rsp_match<=(sr_out==cmd word). An unshifted copy of the cmd word is kept for this comparison. Go to RESP.
- RESP: rsp_valid=1; rsp_data and rsp_match are held stable. When rsp_ready=1, return to IDLE.
- cmd_valid is ignored outside IDLE; a command is never accepted in the same cycle a response completes.
- sr_d is 0 whenever sr_en=0. sr_dir holds dir_q from acceptance until the next acceptance (reset value 0).
- The controller never resets or clears the shift register. Bits already in the register are fully overwritten by the MSB shifts.

## Timing

- Reset, effective at the clock edge: state=IDLE, and cmd_ready, sr_d, sr_en, sr_dir, rsp_valid, rsp_data, rsp_match are all 0. cmd_ready is 0 while rst is high and rises in the first cycle after release.
- All outputs are registered or decoded from state only; there is no combinational path from cmd_valid or rsp_ready to outputs.
- Command accepted at edge E0:
  - SHIFT occupies cycles 1..MSB, with sr_en high on exactly those cycles.
  - CAPTURE is cycle MSB+1.
  - rsp_valid rises in cycle MSB+2.
- Minimum command-to-command period is MSB+3 cycles: the RESP handshake, then one IDLE cycle.
- Reset mid-operation (any state) aborts the command:
  - No response is produced.
  - sr_en is 0 from the cycle after the reset edge.
  - The partial contents of the shift register are left as-is.
- rsp_ready held low keeps the controller in RESP indefinitely with cmd_ready=0.

## Test plan

- Reset: rst=1 for 2 cycles, then 0 -> all outputs 0 during reset; cmd_ready=1 in the first cycle after release.
- MSB=4, cmd_dir=0, cmd_data=4'b1011, bench shift-register model attached, rsp_ready=1 -> sr_d=1,0,1,1 on cycles 1-4, sr_en high exactly 4 cycles, rsp_valid in cycle 6, rsp_data=1011, rsp_match=1.
- cmd_dir=1, cmd_data=4'b0110 -> sr_dir=1, sr_d=0,1,1,0 (LSB first), rsp_data=0110, rsp_match=1.
- Backpressure: rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp_valid held, rsp_data stable, cmd_ready=0, no acceptance. Then rsp_ready=1 -> IDLE next cycle and the pending command is accepted.
- Mismatch: model forces sr_out=4'b0000 for cmd_data=4'b1111 -> rsp_data=0000, rsp_match=0.
- rst pulsed after 2 SHIFT cycles -> sr_en=0 the next cycle, no rsp_valid. The next command, 4'b1001 dir=0, completes with rsp_data=1001 and rsp_match=1.
